// File: rtl/lw_sha_pkg.sv
// Shared SHA helpers: word width selection, rotate/small-sigma functions,
// round counts and the message-schedule state encoding.
`ifndef WORD_SIZE
`ifdef CORE_ARCH_S64
`define WORD_SIZE 64
`else
`define WORD_SIZE 32
`endif
`endif

package lw_sha_pkg;

  localparam int WORD_W     = `WORD_SIZE;
  localparam int RIDX_W     = 7;
  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND
  } sched_state_e;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // SHA-256 mode works on the low 32 bits only; upper bits come back zero.
  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x,
                                                      input logic mode);
    logic [63:0] x64;
    logic [31:0] x32;
    logic [63:0] r;
    x64 = 64'(x);
    x32 = x64[31:0];
    if (mode) r = rotr64(x64, 1) ^ rotr64(x64, 8) ^ (x64 >> 7);
    else      r = {32'd0, rotr32(x32, 7) ^ rotr32(x32, 18) ^ (x32 >> 3)};
    return r[WORD_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x,
                                                      input logic mode);
    logic [63:0] x64;
    logic [31:0] x32;
    logic [63:0] r;
    x64 = 64'(x);
    x32 = x64[31:0];
    if (mode) r = rotr64(x64, 19) ^ rotr64(x64, 61) ^ (x64 >> 6);
    else      r = {32'd0, rotr32(x32, 17) ^ rotr32(x32, 19) ^ (x32 >> 10)};
    return r[WORD_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] mode_mask(input logic [WORD_W-1:0] x,
                                                   input logic mode);
    logic [63:0] x64;
    x64 = 64'(x);
    if (!mode) x64[63:32] = '0;
    return x64[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/lw_sha_sched_window.sv
// 16-entry schedule window: win[15] is newest, win[0] is W[t-16].
// Exposes only the taps the expansion needs.
module lw_sha_sched_window
  import lw_sha_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] tap0_o,
  output logic [DATA_W-1:0] tap1_o,
  output logic [DATA_W-1:0] tap9_o,
  output logic [DATA_W-1:0] tap14_o
);

  logic [DATA_W-1:0] win_q [16];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (shift_i) begin
      for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
      win_q[15] <= din_i;
    end
  end

  assign tap0_o  = win_q[0];
  assign tap1_o  = win_q[1];
  assign tap9_o  = win_q[9];
  assign tap14_o = win_q[14];

endmodule

// File: rtl/lw_sha_msg_sched.sv
// Message-schedule generator: passes W[0..15] through while loading the
// window, then expands W[16..N-1] one word per accepted handshake.
module lw_sha_msg_sched
  import lw_sha_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef CORE_ARCH_S64
  input  logic              mode,
`endif
  input  logic              start_i,
  input  logic [WORD_W-1:0] blk_word_i,
  input  logic              blk_valid_i,
  output logic              blk_ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic [RIDX_W-1:0] round_index_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              last_o,
  output logic              busy_o
);

  sched_state_e      state_q, state_d;
  logic [RIDX_W-1:0] t_q, t_d;
  logic              mode_q, mode_d;
  logic              mode_in;
  logic              shift;
  logic [RIDX_W-1:0] t_last;
  logic [WORD_W-1:0] tap0, tap1, tap9, tap14;
  logic [WORD_W-1:0] exp_word;

`ifdef CORE_ARCH_S64
  assign mode_in = mode;
`else
  assign mode_in = 1'b0;
`endif

  lw_sha_sched_window #(
    .DATA_W (WORD_W)
  ) u_window (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .shift_i (shift),
    .din_i   (word_o),
    .tap0_o  (tap0),
    .tap1_o  (tap1),
    .tap9_o  (tap9),
    .tap14_o (tap14)
  );

  assign t_last   = mode_q ? RIDX_W'(ROUNDS_512 - 1) : RIDX_W'(ROUNDS_256 - 1);
  assign exp_word = mode_mask(small_sigma1(tap14, mode_q) + tap9 +
                              small_sigma0(tap1, mode_q) + tap0, mode_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    mode_d       = mode_q;
    word_o       = '0;
    word_valid_o = 1'b0;
    blk_ready_o  = 1'b0;
    shift        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d  = mode_in;
          t_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Zero-latency pass-through: the round engine sees W[0..15] directly.
        word_o       = mode_mask(blk_word_i, mode_q);
        word_valid_o = blk_valid_i;
        blk_ready_o  = word_ready_i;
        if (blk_valid_i && word_ready_i) begin
          shift = 1'b1;
          t_d   = t_q + 1'b1;
          if (t_q == RIDX_W'(15)) state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        word_o       = exp_word;
        word_valid_o = 1'b1;
        if (word_ready_i) begin
          shift = 1'b1;
          if (t_q == t_last) begin
            t_d     = '0;
            state_d = ST_IDLE;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign round_index_o = t_q;
  assign last_o        = word_valid_o && (t_q == t_last);
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: doc/lw_sha_msg_sched.md
# lw_sha_msg_sched

Message-schedule generator feeding the lightweight SHA round datapath: accepts the 16 words of one padded message block and emits the per-round schedule word W[t] with its round index, one round per handshake. It is the producer side of the round engine's `word`/`round_index` inputs. It supports SHA-256 and, on `CORE_ARCH_S64` builds, SHA-512 selected by `mode`. Schedule words are unmasked, as the round datapath consumes them.

## Interface
- `WORD_SIZE` (define): 32 on `CORE_ARCH_S32`, 64 on `CORE_ARCH_S64`. Word width.
- `clk_i  in  1`: single clock.
- `rst_ni  in  1`: reset, asynchronous, active-low.
- `mode  in  1`: present only under `CORE_ARCH_S64`. 0 = SHA-256 (64 rounds, low 32 bits used), 1 = SHA-512 (80 rounds).
- `start_i  in  1`: one-cycle pulse that begins a block.
- `blk_word_i  in  WORD_SIZE`: message word, W[0] first.
- `blk_valid_i  in  1` / `blk_ready_o  out  1`: block-word handshake.
- `word_o  out  WORD_SIZE`: W[t] to the round engine.
- `round_index_o  out  7`: t.
- `word_valid_o  out  1` / `word_ready_i  in  1`: round-word handshake.
- `last_o  out  1`: high with the final round word.
- `busy_o  out  1`: high when not IDLE.

## Operation
- States: IDLE, LOAD, EXPAND.
- **IDLE:**
  - `start_i` latches `mode` into `mode_q`, clears `t`, and moves to LOAD.
  - `mode_q` holds for the whole block; `mode` changes mid-block are ignored.
  - On 32-bit builds `mode_q` is 0.
- **LOAD (t = 0..15):** pass-through.
  - `word_o = blk_word_i`, `word_valid_o = blk_valid_i`, `blk_ready_o = word_ready_i`.
  - On a transfer (both sides handshaking), the word is shifted into the window and t increments.
  - After the transfer at t = 15, the block moves to EXPAND.
- **EXPAND (t = 16..N-1, where N = 64, or 80 if `mode_q`):**
  - `word_valid_o = 1` and `blk_ready_o = 0`.
  - `word_o = σ1(win[14]) + win[9] + σ0(win[1]) + win[0]` mod 2^width.
  - On `word_ready_i`, `word_o` is shifted into the window and t increments.
- **Window:** 16-entry shift register.
  - `win[15]` is the newest entry; `win[0]` = W[t-16].
  - Shifts only on a transfer.
- **SHA-256 functions:** σ0 = ROTR7 ^ ROTR18 ^ SHR3; σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - On 64-bit builds with `mode_q = 0`, only the low 32 bits are used.
  - The upper 32 bits of `word_o` and of window writes are forced to 0.
- **SHA-512 functions:** σ0 = ROTR1 ^ ROTR8 ^ SHR7; σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- **Completion:**
  - `last_o = word_valid_o && t == N-1`.
  - The transfer of the last word returns the block to IDLE.
- **Boundary cases:**
  - `start_i` outside IDLE is ignored.
  - `blk_valid_i` in IDLE or EXPAND is not accepted.
  - `rst_ni` low at any time forces IDLE immediately and discards the partial block.

## Timing
- **Reset values:** state IDLE, t = 0, `mode_q` = 0, window = 0. Outputs: `blk_ready_o` = 0, `word_valid_o` = 0, `last_o` = 0, `busy_o` = 0, `word_o` = 0, `round_index_o` = 0.
- In IDLE, `word_o` and `round_index_o` are 0.
- `start_i` at cycle c makes `busy_o` go high at c+1.
- LOAD has zero latency: a combinational path `blk_valid_i` → `word_valid_o` and `word_ready_i` → `blk_ready_o`.
- EXPAND runs one word per cycle while `word_ready_i` is high.
- Minimum block duration is N cycles from the first LOAD cycle. `busy_o` falls the cycle after the last transfer.
- `round_index_o` = t, valid whenever `busy_o` is high.
- Outputs are stable while `word_valid_o` is high and `word_ready_i` is low.
- The earliest back-to-back block is a `start_i` in the cycle after `busy_o` falls.

## Structure
- `lw_sha_pkg` gains:
  - small-sigma function(s) `small_sigma0`/`small_sigma1` with a mode argument, mirroring the existing rotate helpers;
  - round-count constants `ROUNDS_256 = 64` and `ROUNDS_512 = 80`;
  - the state enum `sched_state_e`.
- One sub-module is natural: `lw_sha_sched_window`, the 16-entry shift register with taps 0, 1, 9, 14 and shift enable.

## Test plan
- **SHA-256 "abc" block:** W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, with `word_ready_i` = 1. Required: round 16 = 0x61626380, round 17 = 0x000F0000, 64 transfers, `last_o` only at index 63, then IDLE.
- **Backpressure:** random `word_ready_i` and `blk_valid_i` stalls. Required: the word sequence is identical to the stall-free run, and `word_o` is held during stalls.
- **SHA-512 (S64, `mode` = 1) "abc" block:** W0 = 0x6162638000000000, W15 = 0x18. Required: round 16 = W0, 80 rounds, `last_o` at index 79. Toggling `mode` mid-block has no effect.
- **`start_i` while busy:** a pulse at t = 30. Required: no restart, and index continuity through 63.
- **Reset mid-block:** `rst_ni` low at t = 20. Required: all outputs reach their reset values asynchronously. A following `start_i` produces a fresh block matching the golden model.
- **All-zero block:** required: every W[t] = 0 for t = 16..63.
